ring_johnson_counter: RTL
=========================

# ring_johnson_counter

Parametrised shift-register counter generalising the 4-bit one-hot ring counter: WIDTH bits, run-time selectable ring or Johnson (twisted-ring) mode, up/down direction, count enable, parallel load, wrap pulse and state-legality flag. Used as a one-hot or glitch-free decoded sequencer (phase generators, scan/strobe drivers) in the sequential-counter library. Fully synchronous, single clock domain.

## Interface
- WIDTH, 4, number of state bits; legal range 2..32.

- Clock  input  1  rising-edge clock.
- Reset  input  1  reset, synchronous, active-high.
- Enable  input  1  advance one step per clock when high.
- Dir  input  1  0 = shift toward MSB, 1 = shift toward LSB.
- Mode  input  1  0 = ring (one-hot), 1 = Johnson.
- Load  input  1  parallel-load strobe.
- Load_value  input  WIDTH  value written on Load.
- Count_out  output  WIDTH  registered counter state.
- Wrap  output  1  registered one-cycle pulse, state returned to seed by a step.
- Legal  output  1  combinational: Count_out is a legal state for the current mode.

## Operation
- Seed: ring = {WIDTH-1 zeros, 1}; Johnson = all zeros. Seed always follows the registered mode (mode_q).
- Priority per edge: Reset > mode change > Load > self-correct (if compiled) > Enable step > hold.
- Reset: mode_q <= Mode; Count_out <= seed(Mode); Wrap <= 0.
- Mode change (Mode != mode_q): mode_q <= Mode; Count_out <= seed(Mode); no step; Wrap <= 0.
- Load: Count_out <= Load_value unchecked; Wrap <= 0; Enable ignored that cycle.
- Step, ring: Dir=0 -> {q[W-2:0], q[W-1]}; Dir=1 -> {q[0], q[W-1:1]}.
- Step, Johnson: Dir=0 -> {q[W-2:0], ~q[W-1]}; Dir=1 -> {~q[0], q[W-1:1]}.
- Period: ring WIDTH steps, Johnson 2*WIDTH steps, either direction. Dir may change any cycle; next step uses new Dir.
- Wrap <= 1 only when an Enable step produces the seed; 0 after hold, load, reset, reseed or correction.
- Legal, ring: exactly one bit set. Legal, Johnson: at most one i in 0..W-2 with q[i] != q[i+1].
- Enable low: state held, Wrap <= 0.

## Timing
- All state changes on rising Clock; inputs sampled at that edge; one-cycle latency to Count_out and Wrap.
- Reset effective at first edge it is sampled high; mid-count Reset discards state. Before first Reset, contents undefined.
- Wrap high for exactly one cycle per return to seed; with Enable held high, Wrap high every WIDTH (ring) or 2*WIDTH (Johnson) cycles.
- Legal follows Count_out combinationally, no added latency.

## Configuration
- RING_JOHNSON_SELF_CORRECT_EN defined: when Legal is 0 and no Reset, mode change or Load that edge, Count_out <= seed and Wrap <= 0 regardless of Enable (recovery in one cycle).
- Undefined: illegal states are stepped/held like any other value (ring rotates a multi-hot pattern; Johnson cycles an unintended sequence); Legal still reports. Load remains unchecked in both builds.

## Test plan
- WIDTH=4, Reset, Mode=0, Dir=0, Enable=1 -> Count_out 0001,0010,0100,1000,0001; Wrap high only in the cycle showing 0001 after the fourth step.
- Mode=1, Dir=0 from reset -> 0000,0001,0011,0111,1111,1110,1100,1000,0000; Wrap once per 8 steps; Legal=1 throughout.
- Ring at 0100, Dir=1 -> 0010,0001 (Wrap=1),1000; Enable=0 for 3 cycles holds 1000, Wrap=0.
- Ring, Load=1 Load_value=0110 -> Count_out 0110, Legal=0; macro defined: next edge 0001, Wrap=0; undefined: next step 1100.
- Mode toggled 0->1 while Count_out=0100 with Enable=1 -> next Count_out 0000, Wrap=0; Reset asserted together with Load=1 -> seed, Load ignored.

Source files
------------

// File: rtl/ring_johnson_counter_if.sv
// Control/status bundle for ring_johnson_counter: step/load controls in, state and flags out.
interface ring_johnson_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             Enable;
  logic             Dir;
  logic             Mode;
  logic             Load;
  logic [WIDTH-1:0] Load_value;
  logic [WIDTH-1:0] Count_out;
  logic             Wrap;
  logic             Legal;

  modport master (
    output Enable, Dir, Mode, Load, Load_value,
    input  Count_out, Wrap, Legal
  );

  modport slave (
    input  Enable, Dir, Mode, Load, Load_value,
    output Count_out, Wrap, Legal
  );
endinterface

// File: rtl/ring_johnson_counter.sv
// WIDTH-bit ring / Johnson shift counter with up/down, load, wrap pulse and legality flag.
// Optional build macro RING_JOHNSON_SELF_CORRECT_EN: illegal states reseed in one cycle.
module ring_johnson_counter #(
  parameter int unsigned WIDTH = 4
) (
  input logic                   Clock,
  input logic                   Reset,
  ring_johnson_counter_if.slave bus
);

  typedef enum logic {
    MODE_RING    = 1'b0,
    MODE_JOHNSON = 1'b1
  } mode_e;

  mode_e            mode_q, mode_d, mode_in;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] step;
  logic [WIDTH-2:0] edges;
  logic             legal;

  function automatic logic [WIDTH-1:0] seed_of(input mode_e m);
    return (m == MODE_RING) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
  endfunction

  assign mode_in = mode_e'(bus.Mode);

  // Johnson differs from ring only by inverting the bit fed back around the end.
  always_comb begin
    step = count_q;
    if (!bus.Dir) begin
      step = {count_q[WIDTH-2:0],
              (mode_q == MODE_JOHNSON) ? ~count_q[WIDTH-1] : count_q[WIDTH-1]};
    end else begin
      step = {(mode_q == MODE_JOHNSON) ? ~count_q[0] : count_q[0],
              count_q[WIDTH-1:1]};
    end
  end

  assign edges = count_q[WIDTH-2:0] ^ count_q[WIDTH-1:1];

  always_comb begin
    legal = 1'b0;
    if (mode_q == MODE_RING) legal = ($countones(count_q) == 1);
    else                     legal = ($countones(edges) <= 1);
  end

  always_comb begin
    mode_d  = mode_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (Reset) begin
      mode_d  = mode_in;
      count_d = seed_of(mode_in);
    end else if (mode_in != mode_q) begin
      mode_d  = mode_in;
      count_d = seed_of(mode_in);
    end else if (bus.Load) begin
      count_d = bus.Load_value;
`ifdef RING_JOHNSON_SELF_CORRECT_EN
    end else if (!legal) begin
      count_d = seed_of(mode_q);
`endif
    end else if (bus.Enable) begin
      count_d = step;
      wrap_d  = (step == seed_of(mode_q));
    end
  end

  always_ff @(posedge Clock) begin
    mode_q  <= mode_d;
    count_q <= count_d;
    wrap_q  <= wrap_d;
  end

  assign bus.Count_out = count_q;
  assign bus.Wrap      = wrap_q;
  assign bus.Legal     = legal;

endmodule
